// File: rtl/nes_controller_responder_pkg.sv
// Shared definitions for the NES joypad responder and its console-side partner.
package nes_ctrl_pkg;

  localparam int unsigned NES_N_BUTTONS = 8;
  localparam int unsigned NES_COUNT_W   = 4;

  typedef enum logic [2:0] {
    BTN_A      = 3'd0,
    BTN_B      = 3'd1,
    BTN_SELECT = 3'd2,
    BTN_START  = 3'd3,
    BTN_UP     = 3'd4,
    BTN_DOWN   = 3'd5,
    BTN_LEFT   = 3'd6,
    BTN_RIGHT  = 3'd7
  } btn_idx_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/nes_controller_responder_if.sv
// Console-facing strobes, button inputs and status of the joypad responder.
interface nes_controller_responder_if
  import nes_ctrl_pkg::*;
#(
  parameter int unsigned N_BUTTONS = NES_N_BUTTONS
);

  logic [N_BUTTONS-1:0]   buttons;
  logic                   latch_in;
  logic                   pulse_in;
  logic                   controller_out;
  logic                   busy;
  logic [NES_COUNT_W-1:0] bit_count;
  logic                   frame_done;

  // Console / stimulus side
  modport master (
    output buttons, latch_in, pulse_in,
    input  controller_out, busy, bit_count, frame_done
  );

  // Responder side
  modport slave (
    input  buttons, latch_in, pulse_in,
    output controller_out, busy, bit_count, frame_done
  );

endinterface

// File: rtl/nes_controller_responder_strobe_conditioner.sv
// Synchronizes an async strobe, rejects short glitches and flags filtered edges.
module strobe_conditioner #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  localparam int unsigned CNT_W = (FILTER_CYCLES < 2) ? 1 : $clog2(FILTER_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   level_d_q;
  logic                   sampled;

  assign sampled = sync_q[SYNC_STAGES-1];

  // Synchronizer chain, then a level that only flips after a full run of disagreeing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      level     <= 1'b0;
      level_d_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], din};
      level_d_q <= level;
      if (sampled != level) begin
        if (cnt_q == CNT_W'(FILTER_CYCLES - 1)) begin
          level <= ~level;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  // Edge flags valid for the cycle after the filtered level changes
  always_comb begin
    rise_c = level & ~level_d_q;
    fall_c = ~level & level_d_q;
  end

endmodule

// File: rtl/nes_controller_responder.sv
// Controller-side responder: snapshots buttons on latch, shifts them out on pulse.
module nes_controller_responder
  import nes_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 4,
  parameter int unsigned N_BUTTONS     = NES_N_BUTTONS,
  parameter bit          FILL_BIT      = 1'b1
) (
  input logic                       clk,
  input logic                       Reset,
  nes_controller_responder_if.slave bus
);

  localparam int unsigned CNT_W = NES_COUNT_W;

  if (N_BUTTONS < 1 || N_BUTTONS > 15) begin : g_bad_n_buttons
    $error("N_BUTTONS must be 1..15 to fit the 4-bit bit_count");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (FILTER_CYCLES < 1) begin : g_bad_filter
    $error("FILTER_CYCLES must be at least 1");
  end

  ctrl_state_e          state_q, state_d;
  logic [N_BUTTONS-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]     cnt_d;
  logic                 done_d;
  logic                 busy_d;

  logic latch_f, latch_rise_c, latch_fall_c;
  logic pulse_f, pulse_rise_c, pulse_fall_c;
  logic unused_edges;

  assign unused_edges = &{1'b0, latch_rise_c, pulse_f, pulse_fall_c};

  strobe_conditioner #(
    .SYNC_STAGES   (SYNC_STAGES),
    .FILTER_CYCLES (FILTER_CYCLES)
  ) u_latch_cond (
    .clk    (clk),
    .rst    (Reset),
    .din    (bus.latch_in),
    .level  (latch_f),
    .rise_c (latch_rise_c),
    .fall_c (latch_fall_c)
  );

  strobe_conditioner #(
    .SYNC_STAGES   (SYNC_STAGES),
    .FILTER_CYCLES (FILTER_CYCLES)
  ) u_pulse_cond (
    .clk    (clk),
    .rst    (Reset),
    .din    (bus.pulse_in),
    .level  (pulse_f),
    .rise_c (pulse_rise_c),
    .fall_c (pulse_fall_c)
  );

  // State, shift register and all outputs; controller_out tracks the next reg[0]
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q            <= IDLE;
      sreg_q             <= {N_BUTTONS{FILL_BIT}};
      bus.controller_out <= FILL_BIT;
      bus.bit_count      <= '0;
      bus.busy           <= 1'b0;
      bus.frame_done     <= 1'b0;
    end else begin
      state_q            <= state_d;
      sreg_q             <= sreg_d;
      bus.controller_out <= sreg_d[0];
      bus.bit_count      <= cnt_d;
      bus.busy           <= busy_d;
      bus.frame_done     <= done_d;
    end
  end

  // Next state: latch always wins over a coincident pulse; LOAD is transparent to buttons
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = bus.bit_count;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (latch_f) begin
          state_d = LOAD;
          sreg_d  = bus.buttons;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        cnt_d = '0;
        if (latch_fall_c) begin
          state_d = SHIFT;
        end else begin
          sreg_d = bus.buttons;
        end
      end
      SHIFT: begin
        if (latch_f) begin
          state_d = LOAD;
          sreg_d  = bus.buttons;
          cnt_d   = '0;
        end else if (pulse_rise_c) begin
          sreg_d = N_BUTTONS'({FILL_BIT, sreg_q} >> 1);
          cnt_d  = bus.bit_count + CNT_W'(1);
          if (cnt_d == CNT_W'(N_BUTTONS)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      DONE: begin
        if (latch_f) begin
          state_d = LOAD;
          sreg_d  = bus.buttons;
          cnt_d   = '0;
        end else if (pulse_rise_c) begin
          sreg_d = N_BUTTONS'({FILL_BIT, sreg_q} >> 1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == LOAD) || (state_d == SHIFT);
  end

endmodule

// File: tb/tb_nes_controller_responder.sv
// Directed bench for the NES joypad responder: table of frames plus corner sequences.
module tb_nes_controller_responder;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   done_cnt;

  nes_controller_responder_if #(.N_BUTTONS(8)) bus ();

  nes_controller_responder #(
    .SYNC_STAGES   (2),
    .FILTER_CYCLES (4),
    .N_BUTTONS     (8),
    .FILL_BIT      (1'b1)
  ) dut (
    .clk   (clk),
    .Reset (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count frame_done pulses away from the active edge
  always @(negedge clk) begin
    if (bus.frame_done === 1'b1) done_cnt++;
  end

  typedef struct {
    logic [7:0] buttons;
    logic [7:0] exp_serial;  // expected serial bits, [0] first on the wire
    int         n_pulses;
    int         exp_count;
    int         exp_done;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[3];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Latch (buttons change mid-latch to prove transparency), then n pulses of 6 hi / 6 lo
  task automatic run_frame(input vec_t v);
    logic [7:0] dec;
    int         d0;
    int         exp_cnt;
    logic       exp_out;
    bus.buttons  = ~v.buttons;
    bus.latch_in = 1'b1;
    tick(4);
    bus.buttons = v.buttons;
    tick(8);
    check("load_busy", 32'(bus.busy), 32'd1);
    check("load_count", 32'(bus.bit_count), 32'd0);
    check("load_out", 32'(bus.controller_out), 32'(v.exp_serial[0]));
    bus.latch_in = 1'b0;
    tick(10);
    bus.buttons = ~v.buttons;
    check("shift_out0", 32'(bus.controller_out), 32'(v.exp_serial[0]));
    dec    = 8'h00;
    dec[0] = bus.controller_out;
    d0     = done_cnt;
    for (int p = 0; p < v.n_pulses; p++) begin
      bus.pulse_in = 1'b1;
      tick(6);
      bus.pulse_in = 1'b0;
      tick(6);
      exp_out = (p + 1 < 8) ? v.exp_serial[p + 1] : 1'b1;
      exp_cnt = (p + 1 < 8) ? p + 1 : 8;
      check("serial_bit", 32'(bus.controller_out), 32'(exp_out));
      check("bit_count", 32'(bus.bit_count), 32'(exp_cnt));
      if (p + 1 < 8) dec[p + 1] = bus.controller_out;
    end
    check("frame_count", 32'(bus.bit_count), 32'(v.exp_count));
    check("frame_busy", 32'(bus.busy), 32'(v.exp_busy));
    check("frame_done_pulses", 32'(done_cnt - d0), 32'(v.exp_done));
    if (v.n_pulses >= 7) check("decoded_buttons", 32'(dec), 32'(v.exp_serial));
  endtask

  initial begin
    vec_t v;
    int   d0;
    n_checks     = 0;
    n_fail       = 0;
    done_cnt     = 0;
    bus.buttons  = 8'h00;
    bus.latch_in = 1'b0;
    bus.pulse_in = 1'b0;

    vecs[0] = '{buttons: 8'hA5, exp_serial: 8'b1010_0101, n_pulses: 10, exp_count: 8, exp_done: 1, exp_busy: 1'b0};
    vecs[1] = '{buttons: 8'h00, exp_serial: 8'b0000_0000, n_pulses: 8,  exp_count: 8, exp_done: 1, exp_busy: 1'b0};
    vecs[2] = '{buttons: 8'h81, exp_serial: 8'b1000_0001, n_pulses: 7,  exp_count: 7, exp_done: 0, exp_busy: 1'b1};

    // Reset and idle
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    check("reset_frame_done", 32'(bus.frame_done), 32'd0);
    for (int i = 0; i < 100; i++) begin
      check("idle_out_busy_count", {26'd0, bus.controller_out, bus.busy, bus.bit_count},
            {26'd0, 1'b1, 1'b0, 4'd0});
    end

    // Latch edge to LOAD takes 7 cycles
    bus.buttons  = 8'h02;
    bus.latch_in = 1'b1;
    tick(6);
    check("latency_before", 32'(bus.busy), 32'd0);
    check("latency_out_before", 32'(bus.controller_out), 32'd1);
    tick(1);
    check("latency_busy", 32'(bus.busy), 32'd1);
    check("latency_out", 32'(bus.controller_out), 32'd0);
    tick(5);
    bus.latch_in = 1'b0;
    tick(10);

    // Table of frames
    for (int i = 0; i < 3; i++) run_frame(vecs[i]);

    // Glitches mid-frame after 3 pulses (C3: bit3 = 0)
    v = '{buttons: 8'hC3, exp_serial: 8'b1100_0011, n_pulses: 3, exp_count: 3, exp_done: 0, exp_busy: 1'b1};
    run_frame(v);
    bus.latch_in = 1'b1;
    tick(2);
    bus.latch_in = 1'b0;
    tick(20);
    check("glitch_latch_count", 32'(bus.bit_count), 32'd3);
    check("glitch_latch_out", 32'(bus.controller_out), 32'd0);
    check("glitch_latch_busy", 32'(bus.busy), 32'd1);
    bus.pulse_in = 1'b1;
    tick(3);
    bus.pulse_in = 1'b0;
    tick(20);
    check("glitch_pulse_count", 32'(bus.bit_count), 32'd3);
    check("glitch_pulse_out", 32'(bus.controller_out), 32'd0);

    // Re-latch mid-frame with all buttons pressed
    v = '{buttons: 8'hFF, exp_serial: 8'hFF, n_pulses: 8, exp_count: 8, exp_done: 1, exp_busy: 1'b0};
    run_frame(v);

    // Coincident strobes (96: b0=0, b1=1, b2=1)
    v = '{buttons: 8'h96, exp_serial: 8'b1001_0110, n_pulses: 2, exp_count: 2, exp_done: 0, exp_busy: 1'b1};
    run_frame(v);
    bus.buttons = 8'h96;
    d0 = done_cnt;
    bus.latch_in = 1'b1;
    bus.pulse_in = 1'b1;
    tick(6);
    bus.pulse_in = 1'b0;
    tick(6);
    check("latch_wins_count", 32'(bus.bit_count), 32'd0);
    check("latch_wins_busy", 32'(bus.busy), 32'd1);
    check("latch_wins_out", 32'(bus.controller_out), 32'd0);
    bus.latch_in = 1'b0;
    bus.pulse_in = 1'b1;
    tick(6);
    bus.pulse_in = 1'b0;
    tick(6);
    check("fall_pulse_count", 32'(bus.bit_count), 32'd0);
    check("fall_pulse_out", 32'(bus.controller_out), 32'd0);
    check("fall_pulse_busy", 32'(bus.busy), 32'd1);
    bus.pulse_in = 1'b1;
    tick(6);
    bus.pulse_in = 1'b0;
    tick(6);
    check("after_drop_count", 32'(bus.bit_count), 32'd1);
    check("after_drop_out", 32'(bus.controller_out), 32'd1);
    check("coincident_no_done", 32'(done_cnt - d0), 32'd0);

    // Reset mid-frame after 5 pulses
    v = '{buttons: 8'h5A, exp_serial: 8'b0101_1010, n_pulses: 5, exp_count: 5, exp_done: 0, exp_busy: 1'b1};
    run_frame(v);
    d0  = done_cnt;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("midreset_out", 32'(bus.controller_out), 32'd1);
    check("midreset_count", 32'(bus.bit_count), 32'd0);
    check("midreset_busy", 32'(bus.busy), 32'd0);
    check("midreset_frame_done", 32'(bus.frame_done), 32'd0);
    tick(20);
    check("midreset_no_done", 32'(done_cnt - d0), 32'd0);
    check("midreset_idle_busy", 32'(bus.busy), 32'd0);

    // Loop-back decode from IDLE
    v = '{buttons: 8'h3C, exp_serial: 8'b0011_1100, n_pulses: 8, exp_count: 8, exp_done: 1, exp_busy: 1'b0};
    run_frame(v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
